decoder_nto2n_strobe: RTL and testbench
=======================================

// Module: decoder_nto2n_strobe
// PURPOSE
//  Parametrised N-to-2^N decoder with a sequential strobe engine: accepts an N-bit
//  select code over a valid/ready handshake, drives the decoded one-hot line for
//  HOLD cycles, then forces GAP idle cycles before the next code. Generalises the
//  2-to-4 decoder into a chip-select / write-strobe generator for peripheral banks.
// PARAMETERS
//  N     2  select code width; y width is 2**N (N >= 1)
//  HOLD  1  cycles each one-hot strobe stays asserted (HOLD >= 1)
//  GAP   0  forced all-zero cycles after each strobe (GAP >= 0)
// PORTS
//  clk    in   1      clock, all state on rising edge
//  rst    in   1      synchronous reset, active-high
//  en     in   1      global enable; 0 blocks accepts and aborts an active strobe
//  a      in   N      select code, sampled on accept
//  valid  in   1      a is valid this cycle
//  ready  out  1      block can accept a code this cycle
//  y      out  2**N   decoded one-hot strobe (all-zero when inactive)
//  busy   out  1      1 in STROBE or GAP
//  done   out  1      1-cycle pulse on the last STROBE cycle
// BEHAVIOUR
//  - Fully synchronous; rst sampled at clk edge, priority over everything.
//  - Reset values: state=IDLE, y=0, busy=0, done=0, counter=0, latched code=0.
//  - ready = (state==IDLE) & en & ~rst (combinational). Accept = valid & ready.
//  - FSM states: IDLE, STROBE, GAP.
//    IDLE  : accept -> latch a, counter=HOLD-1, go STROBE.
//    STROBE: y = 1 << code; counter decrements each cycle; when counter==0:
//            done=1, then -> GAP (counter=GAP-1) if GAP>0, else -> IDLE.
//    GAP   : y=0; counter decrements; at 0 -> IDLE.
//  - Latency: accept at edge k -> y one-hot in cycles k+1..k+HOLD (registered y);
//    ready re-asserts at cycle k+HOLD+GAP+1 at earliest.
//  - Back-to-back: no accept during final STROBE/GAP cycle; min spacing between
//    accepts = HOLD+GAP+1 cycles.
//  - a/valid changes while busy are ignored; no internal queueing.
//  - en=0 in STROBE or GAP: next edge -> IDLE, y=0, counter=0, done not pulsed.
//  - rst mid-strobe: next edge y=0, IDLE; no done pulse.
//  - y is always exactly zero or one-hot; never more than one bit set.
//  - Counter width $clog2(max(HOLD,GAP)+1); no wrap-around possible by construction.
// CONFIGURATION
//  - DECODER_ACTIVE_LOW_EN defined: y is active-low (y = ~onehot); reset and idle
//    value of y is all-ones; selected bit is 0 during STROBE. All other ports and
//    timing unchanged.
//  - Not defined: y active-high as described above.
// TESTING (N=2, HOLD=2, GAP=1 unless stated)
//  - rst=1 two cycles -> y=0000, ready=0 during rst, busy=0, done=0; ready=1 after.
//  - en=1, valid=1, a=2'b10 at edge k -> y=0100 cycles k+1,k+2, done=1 cycle k+2,
//    y=0000 cycle k+3, ready=1 cycle k+4.
//  - All 8 en x a combos (mirror of 2-to-4 sweep): en=0 -> ready=0, y stays 0000;
//    en=1 -> y = 0001/0010/0100/1000 for a=0..3.
//  - valid held high, a changing every cycle -> accepts only when ready=1; y shows
//    the code latched at accept, exactly 1 accept per 4 cycles.
//  - en dropped on first STROBE cycle of a=3 -> y=0000 next cycle, no done pulse,
//    ready=1 once en returns.
//  - DECODER_ACTIVE_LOW_EN, a=1 -> reset y=1111, strobe y=1101 for 2 cycles, back to 1111.

Source files
------------

// File: rtl/decoder_nto2n_strobe.sv
// N-to-2^N decoder driving a timed one-hot strobe (HOLD cycles) followed by GAP idle cycles; DECODER_ACTIVE_LOW_EN inverts y.
// Latency: accept at edge k -> y valid cycles k+1..k+HOLD, done on the last strobe cycle, ready again at k+HOLD+GAP+1.
// Backpressure: ready only in IDLE with en high and rst low; codes offered while busy are ignored, nothing is queued.
module decoder_nto2n_strobe #(
    parameter int N    = 2,
    parameter int HOLD = 1,
    parameter int GAP  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N-1:0]      a,
    input  logic              valid,
    output logic              ready,
    output logic [2**N-1:0]   y,
    output logic              busy,
    output logic              done
);

    localparam int W    = 2**N;
    localparam int MAXC = (HOLD > GAP) ? HOLD : GAP;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD - 1);
    localparam logic [CW-1:0] GAP_LD  = (GAP > 0) ? CW'(GAP - 1) : '0;

    typedef enum logic [1:0] {S_IDLE, S_STROBE, S_GAP} state_t;

    state_t         state_q, state_n;
    logic [CW-1:0]  cnt_q, cnt_n;
    logic [N-1:0]   code_q, code_n;
    logic [W-1:0]   onehot_q, onehot_n;
    logic           accept;

    assign ready  = (state_q == S_IDLE) & en & ~rst;
    assign accept = valid & ready;
    assign busy   = (state_q != S_IDLE);
    // An aborting en/rst in the final strobe cycle suppresses the completion pulse.
    assign done   = (state_q == S_STROBE) & (cnt_q == '0) & en & ~rst;

    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        code_n   = code_q;
        onehot_n = '0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    code_n   = a;
                    cnt_n    = HOLD_LD;
                    state_n  = S_STROBE;
                    onehot_n = W'(1) << a;
                end
            end
            S_STROBE: begin
                if (cnt_q == '0) begin
                    if (GAP > 0) begin
                        state_n = S_GAP;
                        cnt_n   = GAP_LD;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    cnt_n    = cnt_q - 1'b1;
                    onehot_n = W'(1) << code_q;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt_q - 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
        if (!en) begin
            state_n  = S_IDLE;
            cnt_n    = '0;
            onehot_n = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            code_q   <= '0;
            onehot_q <= '0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            code_q   <= code_n;
            onehot_q <= onehot_n;
        end
    end

`ifdef DECODER_ACTIVE_LOW_EN
    assign y = ~onehot_q;
`else
    assign y = onehot_q;
`endif

endmodule

// File: tb/tb_decoder_nto2n_strobe.sv
// Randomised and directed bench for decoder_nto2n_strobe (N=2, HOLD=2, GAP=1).
// Reference model tracks each strobe as a timeline: cycles elapsed since accept.
module tb_decoder_nto2n_strobe;

    localparam int N    = 2;
    localparam int HOLD = 2;
    localparam int GAP  = 1;
    localparam int W    = 2**N;

    logic          clk = 1'b0;
    logic          rst, en, valid;
    logic [N-1:0]  a;
    logic          ready, busy, done;
    logic [W-1:0]  y;

    int total = 0;
    int bad   = 0;

    // model state
    bit           m_active = 1'b0;
    int           m_t      = 0;
    int unsigned  m_code   = 0;
    int           dut_accepts = 0;

    decoder_nto2n_strobe #(.N(N), .HOLD(HOLD), .GAP(GAP)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .a     (a),
        .valid (valid),
        .ready (ready),
        .y     (y),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs to model, advance model over the edge.
    task automatic step(input bit r, input bit e, input bit v, input logic [N-1:0] aa);
        logic [W-1:0] exp_y;
        bit exp_ready, exp_busy, exp_done;
        @(posedge clk);
        #1;
        rst = r; en = e; valid = v; a = aa;
        #1;
        exp_y     = '0;
        exp_busy  = m_active;
        exp_ready = !m_active && e && !r;
        exp_done  = 1'b0;
        if (m_active && m_t >= 1 && m_t <= HOLD) begin
            exp_y    = W'(1 << m_code);
            exp_done = (m_t == HOLD) && e && !r;
        end
`ifdef DECODER_ACTIVE_LOW_EN
        exp_y = ~exp_y;
`endif
        chk("ready", {31'b0, ready}, {31'b0, exp_ready});
        chk("y",     {28'b0, y},     {28'b0, exp_y});
        chk("busy",  {31'b0, busy},  {31'b0, exp_busy});
        chk("done",  {31'b0, done},  {31'b0, exp_done});
        if (valid && ready) dut_accepts++;
        if (r) begin
            m_active = 1'b0;
        end else if (m_active) begin
            if (!e || m_t >= HOLD + GAP) m_active = 1'b0;
            else m_t++;
        end else if (v && e) begin
            m_active = 1'b1;
            m_t      = 1;
            m_code   = aa;
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; valid = 1'b0; a = '0;
        // reset held two cycles, then idle with en high
        step(1, 1, 0, 0);
        step(1, 1, 1, 2);
        step(0, 1, 0, 0);

        // single strobe of code 2
        step(0, 1, 1, 2'b10);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0);

        // en x a sweep
        for (int e = 0; e < 2; e++)
            for (int c = 0; c < W; c++) begin
                step(0, e[0], 1, c[N-1:0]);
                for (int i = 0; i < HOLD + GAP; i++) step(0, e[0], 0, 0);
            end

        // valid held high with a changing every cycle: one accept per HOLD+GAP+1
        dut_accepts = 0;
        for (int i = 0; i < 16; i++) step(0, 1, 1, i[N-1:0]);
        chk("accept_rate", dut_accepts, 16 / (HOLD + GAP + 1));
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0);

        // en dropped on the first strobe cycle of code 3
        step(0, 1, 1, 2'b11);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);

        // reset in the middle of a strobe
        step(0, 1, 1, 2'b01);
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);

        // randomised traffic
        for (int i = 0; i < 600; i++)
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) != 0),
                 $urandom_range(0, 1), N'($urandom_range(0, W - 1)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
